usb_data_tx: RTL and testbench

- Upstream packet assembler for the USB transmit path.
- Takes a PID nibble and a byte stream of payload, then emits a complete DATA packet as a byte stream: PID byte, payload bytes, then CRC16 low byte and CRC16 high byte.
- Its output side uses the tx_valid/tx_ready byte handshake consumed by the transmit FSM/PHY stage.
- Computes the USB CRC16 on the fly; no payload buffering beyond a single output holding register.

---
 rtl/usb_data_tx.sv | 119 +++++++++++
 tb/tb_usb_data_tx.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/usb_data_tx.sv
// usb_data_tx: assembles a USB DATA packet (PID byte, payload, CRC16 low/high) onto a valid/ready byte stream
// Ports: clk, reset (async, active-high); send_data/pid/zero_len start a packet;
// in_data/in_valid/in_last/in_ready carry payload in; tx_data/tx_valid/tx_ready carry packet bytes out;
// busy/done/len_err/byte_count report packet status.
module usb_data_tx #(
    parameter int MAX_LEN = 1023,
    parameter int CNT_W   = 11
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             send_data,
    input  logic [3:0]       pid,
    input  logic             zero_len,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic             busy,
    output logic             done,
    output logic             len_err,
    output logic [CNT_W-1:0] byte_count
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] PID   = 3'd1;
    localparam logic [2:0] DATA  = 3'd2;
    localparam logic [2:0] CRC1  = 3'd3;
    localparam logic [2:0] CRC2  = 3'd4;
    localparam logic [2:0] DRAIN = 3'd5;
    logic [2:0]       state;
    logic [3:0]       pid_q;
    logic             zero_q;
    logic [15:0]      crc;
    logic             free;
    logic             acc;
    logic             at_max;
    logic [CNT_W-1:0] cnt_nx;
    // reflected CRC16 (0xA001), one byte LSB-first per call
    function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c;
        for (int i = 0; i < 8; i++) r = (r >> 1) ^ ((r[0] ^ d[i]) ? 16'hA001 : 16'h0000);
        return r;
    endfunction
    // holder may take a new byte when empty or being drained this cycle
    assign free     = !tx_valid || tx_ready;
    assign in_ready = (state == DATA) && free;
    assign acc      = in_valid && in_ready;
    assign cnt_nx   = byte_count + 1'b1;
    assign at_max   = cnt_nx == CNT_W'(MAX_LEN);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            pid_q      <= '0;
            zero_q     <= 1'b0;
            crc        <= 16'hFFFF;
            tx_data    <= '0;
            tx_valid   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            len_err    <= 1'b0;
            byte_count <= '0;
        end else begin
            done <= 1'b0;
            if (tx_ready) tx_valid <= 1'b0;
            case (state)
                IDLE: if (send_data) begin
                    pid_q      <= pid;
                    zero_q     <= zero_len;
                    crc        <= 16'hFFFF;
                    byte_count <= '0;
                    len_err    <= 1'b0;
                    busy       <= 1'b1;
                    state      <= PID;
                end
                PID: if (free) begin
                    tx_data  <= {~pid_q, pid_q};
                    tx_valid <= 1'b1;
                    state    <= zero_q ? CRC1 : DATA;
                end
                DATA: if (acc) begin
                    tx_data    <= in_data;
                    tx_valid   <= 1'b1;
                    crc        <= crc_byte(crc, in_data);
                    byte_count <= cnt_nx;
                    if (in_last || at_max) state <= CRC1;
                    if (!in_last && at_max) len_err <= 1'b1;
                end
                CRC1: if (free) begin
                    tx_data  <= ~crc[7:0];
                    tx_valid <= 1'b1;
                    state    <= CRC2;
                end
                CRC2: if (free) begin
                    tx_data  <= ~crc[15:8];
                    tx_valid <= 1'b1;
                    state    <= DRAIN;
                end
                DRAIN: if (tx_ready) begin
                    tx_valid <= 1'b0;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state      <= IDLE;
                    crc        <= 16'hFFFF;
                    tx_data    <= '0;
                    tx_valid   <= 1'b0;
                    busy       <= 1'b0;
                    len_err    <= 1'b0;
                    byte_count <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_usb_data_tx.sv
// tb_usb_data_tx: scoreboard bench for usb_data_tx (default and MAX_LEN=4 instances)
module tb_usb_data_tx;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        send_data = 1'b0;
    logic [3:0]  pid = '0;
    logic        zero_len = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        tx_ready = 1'b1;
    logic        sel = 1'b0;
    logic        in_ready_a, in_ready_b, tx_valid_a, tx_valid_b, busy_a, busy_b;
    logic        done_a, done_b, len_err_a, len_err_b;
    logic [7:0]  tx_data_a, tx_data_b;
    logic [10:0] byte_count_a, byte_count_b;
    logic        in_ready, tx_valid, busy, done, len_err;
    logic [7:0]  tx_data;
    logic [10:0] byte_count;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          done_cnt = 0;
    int          done_cyc = 0;
    int          rdy_mode = 0;
    int          pi = 0;
    logic [4:0]  pat = 5'b01101;
    logic [8:0]  exp_q[$];
    logic [8:0]  e;
    bit          mon_en = 1'b0;
    bit          pending_done = 1'b0;
    bit          prev_stall = 1'b0;
    logic [7:0]  prev_data = '0;
    usb_data_tx dut_a (
        .clk(clk), .reset(reset), .send_data(send_data), .pid(pid), .zero_len(zero_len),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready_a),
        .tx_data(tx_data_a), .tx_valid(tx_valid_a), .tx_ready(tx_ready), .busy(busy_a),
        .done(done_a), .len_err(len_err_a), .byte_count(byte_count_a)
    );
    usb_data_tx #(.MAX_LEN(4), .CNT_W(11)) dut_b (
        .clk(clk), .reset(reset), .send_data(send_data), .pid(pid), .zero_len(zero_len),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready_b),
        .tx_data(tx_data_b), .tx_valid(tx_valid_b), .tx_ready(tx_ready), .busy(busy_b),
        .done(done_b), .len_err(len_err_b), .byte_count(byte_count_b)
    );
    assign in_ready   = sel ? in_ready_b   : in_ready_a;
    assign tx_valid   = sel ? tx_valid_b   : tx_valid_a;
    assign tx_data    = sel ? tx_data_b    : tx_data_a;
    assign busy       = sel ? busy_b       : busy_a;
    assign done       = sel ? done_b       : done_a;
    assign len_err    = sel ? len_err_b    : len_err_a;
    assign byte_count = sel ? byte_count_b : byte_count_a;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask
    function automatic logic [15:0] crc_model(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        logic        fb;
        r = c;
        for (int i = 0; i < 8; i++) begin
            fb = r[0] ^ d[i];
            r  = r >> 1;
            if (fb) r = r ^ 16'hA001;
        end
        return r;
    endfunction
    initial forever begin
        @(posedge clk);
        #1;
        tx_ready = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? pat[pi % 5] : 1'($urandom_range(0, 1));
        pi++;
    end
    always @(negedge clk) if (mon_en) begin
        if (prev_stall) check("hold", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, prev_data});
        if (in_ready && tx_valid && !tx_ready) check("in_ready_stall", in_ready, 0);
        if (pending_done) begin
            check("done_pulse", done, 1);
            pending_done = 1'b0;
        end else if (done) check("spurious_done", done, 0);
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (tx_valid && tx_ready) begin
            if (exp_q.size() == 0) check("extra_byte", {1'b0, tx_data}, 9'h100);
            else begin
                e = exp_q.pop_front();
                check("tx_byte", {1'b0, tx_data}, e);
                if (exp_q.size() == 0) pending_done = 1'b1;
            end
        end
        prev_stall = tx_valid && !tx_ready;
        prev_data  = tx_data;
    end
    task automatic chk_reset();
        check("rst_tx_valid", tx_valid, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_len_err", len_err, 0);
        check("rst_byte_count", byte_count, 0);
    endtask
    task automatic offer(input logic [7:0] d, input bit l, output bit ok);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        ok       = 1'b0;
        for (int w = 0; w < 40 && !ok; w++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
        end
    endtask
    task automatic send_pkt(input logic [3:0] p, input int n, input bit last, input bit gaps,
                            input int maxlen, input bit timed);
        logic [15:0] c;
        int          acc, nacc, t0, d0;
        bit          ok;
        c   = 16'hFFFF;
        acc = (!last && n > maxlen) ? maxlen : n;
        exp_q.push_back({1'b0, ~p, p});
        for (int i = 0; i < acc; i++) begin
            c = crc_model(c, 8'(i));
            exp_q.push_back({1'b0, 8'(i)});
        end
        exp_q.push_back({1'b0, ~c[7:0]});
        exp_q.push_back({1'b0, ~c[15:8]});
        d0        = done_cnt;
        send_data = 1'b1;
        pid       = p;
        zero_len  = n == 0;
        @(posedge clk);
        #1;
        t0        = cyc;
        send_data = 1'b0;
        check("busy", busy, 1);
        nacc = 0;
        ok   = 1'b1;
        for (int i = 0; i < n && ok; i++) begin
            if (gaps && i == 2) begin
                in_valid = 1'b0;
                @(posedge clk);
                #1;
                check("gap_tx_valid", tx_valid, 0);
                repeat (2) @(posedge clk);
                #1;
            end
            offer(8'(i), last && i == n - 1, ok);
            if (ok) nacc++;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        for (int w = 0; w < 200 && done_cnt == d0; w++) @(posedge clk);
        @(posedge clk);
        #1;
        check("done_count", done_cnt - d0, 1);
        check("accepted", nacc, acc);
        check("byte_count", byte_count, acc);
        check("queue_empty", exp_q.size(), 0);
        check("busy_end", busy, 0);
        if (timed) check("latency", done_cyc - t0, n == 0 ? 4 : n + 4);
    endtask
    initial begin
        bit ok;
        int d0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset();
        reset  = 1'b0;
        mon_en = 1'b1;
        @(posedge clk);
        #1;
        send_pkt(4'h3, 0, 1'b1, 1'b0, 1023, 1'b1);
        send_pkt(4'hB, 4, 1'b1, 1'b0, 1023, 1'b1);
        rdy_mode = 1;
        send_pkt(4'hB, 4, 1'b1, 1'b0, 1023, 1'b0);
        rdy_mode = 2;
        send_pkt(4'hB, 4, 1'b1, 1'b0, 1023, 1'b0);
        send_pkt(4'h5, 20, 1'b1, 1'b0, 1023, 1'b0);
        rdy_mode = 0;
        send_pkt(4'hB, 4, 1'b1, 1'b1, 1023, 1'b0);
        // abort mid-payload: the trailing 9'h1FF entry keeps the scoreboard from expecting done
        exp_q.push_back({1'b0, 8'h4B});
        exp_q.push_back(9'h000);
        exp_q.push_back(9'h001);
        exp_q.push_back(9'h1FF);
        d0        = done_cnt;
        send_data = 1'b1;
        pid       = 4'hB;
        zero_len  = 1'b0;
        @(posedge clk);
        #1;
        send_data = 1'b0;
        for (int i = 0; i < 2; i++) begin
            offer(8'(i), 1'b0, ok);
            check("abort_accept", ok, 1);
        end
        in_valid = 1'b0;
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk_reset();
        check("abort_queue", exp_q.size(), 1);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check("abort_no_done", done_cnt, d0);
        send_pkt(4'h3, 0, 1'b1, 1'b0, 1023, 1'b1);
        sel = 1'b1;
        @(posedge clk);
        #1;
        send_pkt(4'hB, 6, 1'b0, 1'b0, 4, 1'b0);
        check("len_err_set", len_err, 1);
        send_pkt(4'h3, 0, 1'b1, 1'b0, 4, 1'b0);
        check("len_err_clear", len_err, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
